// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - request/data/output handshake bundle for mux4_rr_arbiter
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       req;
  logic [3:0]       lock;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       ack;
  logic [1:0]       select;
  logic [3:0]       gnt;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;

  // requesters plus consumer
  modport master (
    output req, lock, a, b, c, d, q_ready,
    input  ack, select, gnt, q, q_valid
  );

  // arbiter
  modport slave (
    input  req, lock, a, b, c, d, q_ready,
    output ack, select, gnt, q, q_valid
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - 4-way round-robin arbiter with lock bursts and registered output stage
module mux4_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux4_rr_arbiter_if.slave   bus
);
  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic [1:0]       select_r;
  logic [3:0]       gnt_r;
  logic [1:0]       ptr_r;
  logic [BW-1:0]    bcount_r;
  logic             hold_r;

  logic [1:0]       rr_win;
  logic [1:0]       idx;
  logic             found;
  logic             use_hold;
  logic [1:0]       win_code;
  logic [WIDTH-1:0] win_data;
  logic             any_req;
  logic             xfer;
  logic [BW-1:0]    bcount_inc;
  logic             burst_more;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    rr_win = ptr_r;
    found  = 1'b0;
    idx    = ptr_r;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_r + 2'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        rr_win = idx;
      end
    end
  end

  assign any_req    = |bus.req;
  assign use_hold   = hold_r && bus.req[select_r];
  assign win_code   = use_hold ? select_r : rr_win;
  assign xfer       = q_valid_r && bus.q_ready;
  assign bcount_inc = bcount_r + BW'(1);
  assign burst_more = bus.lock[select_r] && (bcount_inc < BW'(MAX_BURST));

  always_comb begin
    case (win_code)
      2'd0:    win_data = bus.a;
      2'd1:    win_data = bus.b;
      2'd2:    win_data = bus.c;
      default: win_data = bus.d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (xfer)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
      select_r  <= 2'd0;
      gnt_r     <= 4'd0;
      ptr_r     <= 2'd0;
      bcount_r  <= '0;
      hold_r    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            select_r  <= win_code;
            gnt_r     <= 4'b0001 << win_code;
            q_r       <= win_data;
            q_valid_r <= 1'b1;
            if (!use_hold) begin
              ptr_r  <= rr_win + 2'd1;
              hold_r <= 1'b0;
            end
            if (win_code != select_r) bcount_r <= '0;
          end
        end
        BUSY: begin
          if (xfer) begin
            q_valid_r <= 1'b0;
            gnt_r     <= 4'd0;
            // Burst accounting happens once per delivered beat.
            if (burst_more) begin
              hold_r   <= 1'b1;
              bcount_r <= bcount_inc;
            end else begin
              hold_r   <= 1'b0;
              bcount_r <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.select  = select_r;
  assign bus.gnt     = gnt_r;
  assign bus.ack     = gnt_r & {4{xfer}};
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mux4_rr_arbiter_if #(.WIDTH(32)) bus ();

  mux4_rr_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DA = 32'hA0000000;
  localparam logic [31:0] DB = 32'hB0000001;
  localparam logic [31:0] DC = 32'hCAFE0002;
  localparam logic [31:0] DD = 32'hD0000003;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req     = 4'd0;
    bus.lock    = 4'd0;
    bus.q_ready = 1'b0;
    bus.a = DA; bus.b = DB; bus.c = DC; bus.d = DD;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int s);
    case (s)
      0:       return DA;
      1:       return DB;
      2:       return DC;
      default: return DD;
    endcase
  endfunction

  // One beat with q_ready=1: grant edge, then transfer edge into the bubble.
  task automatic beat(input string tag, input int s);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    @(posedge clk); #1;
    chk({tag, "_select"}, {30'd0, bus.select}, 32'(s));
    chk({tag, "_gnt"}, {28'd0, bus.gnt}, {28'd0, oh});
    chk({tag, "_q"}, bus.q, word_of(s));
    chk({tag, "_qvalid"}, {31'd0, bus.q_valid}, 32'd1);
    chk({tag, "_ack"}, {28'd0, bus.ack}, {28'd0, oh});
    @(posedge clk); #1;
    chk({tag, "_bubble_qvalid"}, {31'd0, bus.q_valid}, 32'd0);
    chk({tag, "_bubble_gnt"}, {28'd0, bus.gnt}, 32'd0);
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_qvalid", {31'd0, bus.q_valid}, 32'd0);
      chk("idle_gnt", {28'd0, bus.gnt}, 32'd0);
      chk("idle_select", {30'd0, bus.select}, 32'd0);
      chk("idle_q", bus.q, 32'd0);
      chk("idle_ack", {28'd0, bus.ack}, 32'd0);
    end

    // single requester c, two words in four cycles
    do_reset();
    bus.req = 4'b0100; bus.q_ready = 1'b1;
    beat("single0", 2);
    beat("single1", 2);
    bus.req = 4'd0;

    // round-robin fairness
    do_reset();
    bus.req = 4'b1111; bus.q_ready = 1'b1;
    beat("rr0", 0); beat("rr1", 1); beat("rr2", 2);
    beat("rr3", 3); beat("rr4", 0); beat("rr5", 1);
    bus.req = 4'd0;

    // burst cap with a locked
    do_reset();
    bus.req = 4'b0011; bus.lock = 4'b0001; bus.q_ready = 1'b1;
    beat("bu0", 0); beat("bu1", 0); beat("bu2", 0); beat("bu3", 0); beat("bu4", 1);
    beat("bu5", 0); beat("bu6", 0); beat("bu7", 0); beat("bu8", 0); beat("bu9", 1);
    bus.req = 4'd0; bus.lock = 4'd0;

    // backpressure
    do_reset();
    bus.a = 32'h12345678; bus.req = 4'b0001;
    @(posedge clk); #1;
    chk("bp_grant_select", {30'd0, bus.select}, 32'd0);
    bus.req = 4'b1111; bus.b = 32'h0BADF00D; bus.c = 32'h55555555;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("bp_q", bus.q, 32'h12345678);
      chk("bp_qvalid", {31'd0, bus.q_valid}, 32'd1);
      chk("bp_ack", {28'd0, bus.ack}, 32'd0);
    end
    bus.q_ready = 1'b1; #1;
    chk("bp_ack_ready", {28'd0, bus.ack}, 32'd1);
    @(posedge clk); #1;
    chk("bp_after_qvalid", {31'd0, bus.q_valid}, 32'd0);
    chk("bp_after_ack", {28'd0, bus.ack}, 32'd0);
    @(posedge clk); #1;
    chk("bp_next_select", {30'd0, bus.select}, 32'd1);
    chk("bp_next_q", bus.q, 32'h0BADF00D);

    // reset mid-transfer
    do_reset();
    bus.req = 4'b0100;
    @(posedge clk); #1;
    chk("rm_busy_qvalid", {31'd0, bus.q_valid}, 32'd1);
    reset = 1'b1; bus.q_ready = 1'b1; #1;
    chk("rm_qvalid", {31'd0, bus.q_valid}, 32'd0);
    chk("rm_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rm_ack", {28'd0, bus.ack}, 32'd0);
    chk("rm_select", {30'd0, bus.select}, 32'd0);
    chk("rm_q", bus.q, 32'd0);
    @(posedge clk); #1;
    chk("rm_hold_ack", {28'd0, bus.ack}, 32'd0);
    reset = 1'b0; bus.req = 4'b1111;
    beat("rm_after", 0);
    bus.req = 4'd0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
